// File: rtl/spike_enc_pkg.sv
// Shared constants and types for the rate-coded spike encoder and its LFSR.
package spike_enc_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned INT_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NUM_CH = 3;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_e;

  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  // An all-zero seed would lock the LFSR; substitute the smallest legal value.
  function automatic logic [LFSR_W-1:0] lfsr_fix_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? LFSR_W'(1) : seed;
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with enable; reloads a nonzero seed on reset.
module lfsr16_galois
  import spike_enc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_q;
  logic [LFSR_W-1:0] value_d;

  // Next value: shift right, fold the tap mask in when a one falls out.
  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = value_q >> 1;
      if (value_q[0]) begin
        value_d = value_d ^ LFSR_TAPS;
      end
    end
  end

  // State register, reseeded by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= lfsr_fix_seed(seed);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/spike_rate_encoder_3ch.sv
// Three-channel rate-coded spike encoder feeding a 3-input LIF neuron.
// Optional feature: SPIKE_ENC_REFRACTORY_EN suppresses a channel for one
// step after it spikes.
module spike_rate_encoder_3ch
  import spike_enc_pkg::*;
#(
  parameter int unsigned       WINDOW    = 100,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_i0,
  input  logic [INT_W-1:0] in_i1,
  input  logic [INT_W-1:0] in_i2,
  output logic             x0,
  output logic             x1,
  output logic             x2,
  output logic             busy,
  output logic             window_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INT_W-1:0]  i0_q, i0_d;
  logic [INT_W-1:0]  i1_q, i1_d;
  logic [INT_W-1:0]  i2_q, i2_d;
  logic [NUM_CH-1:0] x_q, x_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] raw;
  logic              lfsr_en;
  logic [LFSR_W-1:0] lfsr_val;
`ifdef SPIKE_ENC_REFRACTORY_EN
  logic [NUM_CH-1:0] refr_q, refr_d;
`endif

  // One Bernoulli trial: saturate at full scale, otherwise random below intensity.
  function automatic logic spike(input logic [INT_W-1:0] rnd, input logic [INT_W-1:0] inten);
    return (inten == 8'hFF) || (rnd < inten);
  endfunction

  assign lfsr_en = (state_q == ST_RUN);

  lfsr16_galois u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  // Raw spike decisions from the current (pre-advance) LFSR slices.
  always_comb begin
    raw    = '0;
    raw[0] = spike(lfsr_val[7:0],  i0_q);
    raw[1] = spike(lfsr_val[15:8], i1_q);
    raw[2] = spike(lfsr_val[11:4], i2_q);
  end

  // FSM, step counter, intensity latches and spike output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    x_d     = '0;
    done_d  = 1'b0;
`ifdef SPIKE_ENC_REFRACTORY_EN
    refr_d  = refr_q;
`endif
    if (state_q == ST_IDLE) begin
      if (in_valid) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        i0_d    = in_i0;
        i1_d    = in_i1;
        i2_d    = in_i2;
`ifdef SPIKE_ENC_REFRACTORY_EN
        refr_d  = '0;
`endif
      end
    end else begin
`ifdef SPIKE_ENC_REFRACTORY_EN
      x_d    = raw & ~refr_q;
      refr_d = x_d;
`else
      x_d    = raw;
`endif
      if (cnt_q == CNT_LAST) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
`ifdef SPIKE_ENC_REFRACTORY_EN
      refr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      x_q     <= x_d;
      done_q  <= done_d;
`ifdef SPIKE_ENC_REFRACTORY_EN
      refr_q  <= refr_d;
`endif
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign x0          = x_q[0];
  assign x1          = x_q[1];
  assign x2          = x_q[2];
  assign window_done = done_q;

endmodule

// File: tb/tb_spike_rate_encoder_3ch.sv
// Self-checking bench: a default-seed encoder and a seed-0 encoder share stimulus
// and are compared every step against a behavioural LFSR/compare model.
module tb_spike_rate_encoder_3ch;

  localparam int unsigned W = 100;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [7:0] in_i0, in_i1, in_i2;

  logic in_ready_a, x0_a, x1_a, x2_a, busy_a, done_a;
  logic in_ready_b, x0_b, x1_b, x2_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr_a, m_lfsr_b;
  logic [2:0]  m_prev_a, m_prev_b;
  int          ones [3];

  always #5 clk = ~clk;

  spike_rate_encoder_3ch #(.WINDOW(W), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_i0(in_i0), .in_i1(in_i1), .in_i2(in_i2),
    .x0(x0_a), .x1(x1_a), .x2(x2_a), .busy(busy_a), .window_done(done_a)
  );

  spike_rate_encoder_3ch #(.WINDOW(W), .LFSR_SEED(16'h0000)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_i0(in_i0), .in_i1(in_i1), .in_i2(in_i2),
    .x0(x0_b), .x1(x1_b), .x2(x2_b), .busy(busy_b), .window_done(done_b)
  );

  // Galois right shift: halve, and xor the tap mask when the value was odd.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] h;
    h = 16'(v / 2);
    return (v % 2 == 1) ? (h ^ 16'hB400) : h;
  endfunction

  // Expected spikes for one step from the current LFSR value.
  function automatic logic [2:0] model_x(input logic [15:0] v, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [2:0] prev);
    logic [7:0] r0, r1, r2;
    logic [2:0] raw;
    r0 = v[7:0];
    r1 = v[15:8];
    r2 = v[11:4];
    raw[0] = (a == 8'd255) || (r0 < a);
    raw[1] = (b == 8'd255) || (r1 < b);
    raw[2] = (c == 8'd255) || (r2 < c);
`ifdef SPIKE_ENC_REFRACTORY_EN
    return raw & ~prev;
`else
    if (prev == 3'b111) return raw;
    return raw;
`endif
  endfunction

  // Hold reset for two edges, release, reseed the models; ends at posedge+1.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, x2_a, x1_a, x0_a} !== 5'b0) begin
      errors++;
      $display("FAIL in_reset_a: got %b expected 00000", {busy_a, done_a, x2_a, x1_a, x0_a});
    end
    checks++;
    if ({busy_b, done_b, x2_b, x1_b, x0_b} !== 5'b0) begin
      errors++;
      $display("FAIL in_reset_b: got %b expected 00000", {busy_b, done_b, x2_b, x1_b, x0_b});
    end
    @(negedge clk);
    reset    = 1'b0;
    m_lfsr_a = 16'hACE1;
    m_lfsr_b = 16'h0001;
    @(posedge clk);
    #1;
  endtask

  // Offer a triple, then check every step of the window; stop_at >= 0 aborts early.
  task automatic run_window(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input bit hold, input bit toggle, input int stop_at);
    logic [2:0] exp_a, exp_b, exp_st;
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b expected 1", in_ready_a);
    end
    in_valid = 1'b1;
    in_i0 = a;
    in_i1 = b;
    in_i2 = c;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    m_prev_a = '0;
    m_prev_b = '0;
    for (int k = 0; k < 3; k++) ones[k] = 0;
    for (int s = 0; s < int'(W); s++) begin
      if (s == stop_at) return;
      exp_a    = model_x(m_lfsr_a, a, b, c, m_prev_a);
      m_prev_a = exp_a;
      m_lfsr_a = lfsr_step(m_lfsr_a);
      exp_b    = model_x(m_lfsr_b, a, b, c, m_prev_b);
      m_prev_b = exp_b;
      m_lfsr_b = lfsr_step(m_lfsr_b);
      if (toggle) begin
        in_i0 = 8'($urandom);
        in_i1 = 8'($urandom);
        in_i2 = 8'($urandom);
      end
      @(posedge clk);
      #1;
      exp_st = (s == int'(W) - 1) ? 3'b101 : 3'b010;
      ones[0] += int'(x0_a);
      ones[1] += int'(x1_a);
      ones[2] += int'(x2_a);
      checks++;
      if ({x2_a, x1_a, x0_a} !== exp_a) begin
        errors++;
        $display("FAIL x_a step %0d: got %b expected %b", s, {x2_a, x1_a, x0_a}, exp_a);
      end
      checks++;
      if ({in_ready_a, busy_a, done_a} !== exp_st) begin
        errors++;
        $display("FAIL status_a step %0d: got %b expected %b", s, {in_ready_a, busy_a, done_a}, exp_st);
      end
      checks++;
      if ({x2_b, x1_b, x0_b} !== exp_b) begin
        errors++;
        $display("FAIL x_b step %0d: got %b expected %b", s, {x2_b, x1_b, x0_b}, exp_b);
      end
      checks++;
      if ({in_ready_b, busy_b, done_b} !== exp_st) begin
        errors++;
        $display("FAIL status_b step %0d: got %b expected %b", s, {in_ready_b, busy_b, done_b}, exp_st);
      end
      checks++;
      if (dut_b.u_lfsr.value === 16'h0000) begin
        errors++;
        $display("FAIL lfsr_b_nonzero step %0d: got 0000 expected nonzero", s);
      end
    end
    in_valid = hold;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready_a, busy_a, done_a, x2_a, x1_a, x0_a} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_a: got %b expected 100000", {in_ready_a, busy_a, done_a, x2_a, x1_a, x0_a});
    end
    checks++;
    if ({in_ready_b, busy_b, done_b, x2_b, x1_b, x0_b} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_b: got %b expected 100000", {in_ready_b, busy_b, done_b, x2_b, x1_b, x0_b});
    end
  endtask

  task automatic test_extremes();
    int exp_ones;
`ifdef SPIKE_ENC_REFRACTORY_EN
    exp_ones = int'(W) / 2;
`else
    exp_ones = int'(W);
`endif
    run_window(8'd0, 8'd255, 8'd0, 1'b0, 1'b0, -1);
    checks++;
    if (ones[1] != exp_ones) begin
      errors++;
      $display("FAIL x1_count: got %0d expected %0d", ones[1], exp_ones);
    end
    checks++;
    if (ones[0] != 0 || ones[2] != 0) begin
      errors++;
      $display("FAIL x0_x2_silent: got %0d/%0d expected 0/0", ones[0], ones[2]);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready_a, busy_a, done_a, x2_a, x1_a, x0_a} !== 6'b100000) begin
      errors++;
      $display("FAIL idle_gap: got %b expected 100000", {in_ready_a, busy_a, done_a, x2_a, x1_a, x0_a});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_window(8'd128, 8'd64, 8'd200, 1'b1, 1'b1, -1);
    run_window(8'd128, 8'd64, 8'd200, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_midwindow();
    do_reset();
    run_window(8'd128, 8'd64, 8'd200, 1'b0, 1'b0, 37);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, x2_a, x1_a, x0_a} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_a: got %b expected 00000", {busy_a, done_a, x2_a, x1_a, x0_a});
    end
    checks++;
    if ({busy_b, done_b, x2_b, x1_b, x0_b} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_b: got %b expected 00000", {busy_b, done_b, x2_b, x1_b, x0_b});
    end
    do_reset();
    run_window(8'd128, 8'd64, 8'd200, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 2; n++) begin
      run_window(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, -1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_i0    = '0;
    in_i1    = '0;
    in_i2    = '0;
    test_reset();
    test_extremes();
    test_back_to_back();
    test_reset_midwindow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spike_rate_encoder_3ch.md
# spike_rate_encoder_3ch

Three-channel rate-coded spike encoder that sits directly upstream of the 3-input online-Hebbian LIF neuron. It accepts three 8-bit intensity samples through a valid/ready handshake and, for a fixed window of time steps, drives binary spike lines x0..x2. On each step a channel spikes with probability proportional to its intensity, using a shared 16-bit LFSR. It produces the pre-synaptic spike trains that the neuron integrates and learns from.

## Interface
- WINDOW, 100: time steps per encoding window, 1..65535.
- LFSR_SEED, 16'hACE1: LFSR value loaded on reset. A seed of 0 is replaced by 16'h0001.
- clk  in  1  clock; one time step per cycle.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  intensity triple offered.
- in_ready  out  1  encoder can accept a triple; high only in IDLE.
- in_i0, in_i1, in_i2  in  8 each  intensities; 0 means never spike, 255 means always spike.
- x0, x1, x2  out  1 each  registered spike outputs; these connect to the neuron's x0..x2.
- busy  out  1  high while in RUN.
- window_done  out  1  one-cycle pulse coincident with the last spike step of the window.

## Operation
- States:
  - IDLE: in_ready=1, x*=0, busy=0.
  - RUN: in_ready=0, busy=1.
- IDLE→RUN on in_valid & in_ready:
  - latch in_i0..2 into I0..I2;
  - clear step counter to 0.
- RUN, every cycle:
  - x_k <= (I_k == 8'hFF) | (rnd_k < I_k), unsigned 8-bit compare;
  - counter increments;
  - LFSR advances once.
- Random slices are taken from the current LFSR value before it advances: rnd0=lfsr[7:0], rnd1=lfsr[15:8], rnd2=lfsr[11:4].
- LFSR: 16-bit Galois, right-shifting, tap mask 16'hB400. It never holds 0.
- The LFSR advances only in RUN. It is not reloaded between windows, so the sequence continues.
- RUN→IDLE after WINDOW steps. window_done is asserted with the final x update.
- in_valid during RUN is ignored; in_i* are not re-sampled.
- Step counter is 16 bits. Its terminal value is WINDOW-1; it never wraps within a window.
- Reset at any time:
  - state=IDLE;
  - x*=0, window_done=0, busy=0;
  - in_ready=1 after reset deasserts;
  - LFSR=seed, counter=0, I*=0.

## Timing
- Reset values: in_ready=1, busy=0, x0=x1=x2=0, window_done=0.
- Accept at edge T. The first x values are visible after edge T+1. The last x values are visible after edge T+WINDOW, together with window_done=1.
- After edge T+WINDOW+1: x*=0, window_done=0, in_ready=1.
- With in_valid held high, the next accept occurs at edge T+WINDOW+1. The gap is one IDLE cycle between windows, in which x*=0.
- x* and window_done are registered with no combinational path from inputs. in_ready and busy are decoded from state registers only.

## Configuration
- SPIKE_ENC_REFRACTORY_EN:
  - Defined: a channel that spiked on step t is forced to 0 on step t+1, regardless of intensity. The LFSR still advances.
  - Intensity 255 then yields alternating 1,0,1,0 over the window.
  - Refractory history clears on entry to RUN.
  - Undefined: no suppression; intensity 255 yields x high for every step.

## Structure
- Package spike_enc_pkg holds:
  - LFSR width (16) and tap mask 16'hB400;
  - state enum {IDLE, RUN};
  - intensity width (8).
- Sub-module lfsr16_galois:
  - ports clk, reset, en, seed, value[15:0];
  - reused by future noise-injection blocks.
- Top module holds the FSM, counter, intensity latches, comparators and optional refractory flops.
- Expected size is roughly 150–250 lines total.

## Test plan
- Intensities (0,255,0), WINDOW=100, macro undefined:
  - x1 high for exactly 100 consecutive cycles;
  - x0 and x2 always 0;
  - window_done is a single pulse on the 100th x cycle;
  - in_ready returns the next cycle.
- Same stimulus with SPIKE_ENC_REFRACTORY_EN defined: x1 shows exactly 50 spikes in pattern 1,0,1,0; window_done timing unchanged.
- Intensities (128,64,200), seed 16'hACE1: per-cycle x0..x2 match a behavioural LFSR/compare model bit-exactly for two back-to-back windows, with the LFSR continuing across windows.
- Handshake: in_valid held high with new data toggled during RUN:
  - in_ready=0 throughout RUN;
  - mid-window data never affects x;
  - the second accept occurs exactly one cycle after window_done.
- Reset asserted asynchronously at step 37:
  - x*, busy and window_done drop immediately;
  - after release, a new window with the same intensities reproduces window 1 bit-exactly, because the LFSR is reseeded.
- LFSR_SEED=0: encoder runs with effective seed 16'h0001, the LFSR never reaches 0, and output matches the model seeded 1.
